tanh_scheduler: RTL and testbench
=================================

TANH_SCHEDULER -- requirements
Module: tanh_scheduler

Interface
REQ-001 Param NUM_REQ, default 4: number of requesters sharing one Tanh engine.
REQ-002 Param DATA_W, default 32: operand/result width.
REQ-003 Param ENG_LAT, default 4, legal range 1..16: engine latency, eng_valid_in to eng_valid_out, in cycles.
REQ-004 Port list, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_data  out  DATA_W  result, shared by all requesters.
- eng_valid_in  out  1  engine operand valid.
- eng_data_in  out  DATA_W  engine operand.
- eng_valid_out  in  1  engine result valid.
- eng_data_out  in  DATA_W  engine result.
- drain_req  in  1  level request to stop issuing and empty the pipe.
- drain_done  out  1  pipe empty, issue halted.
- inflight  out  5  accepted-but-unanswered count.
- err_spurious  out  1  sticky flag: engine result with no matching tag.

Function
REQ-005 Transfer from requester i occurs when req_valid[i] && req_ready[i]; req_ready is combinational from req_valid, state and the RR pointer.
REQ-006 At most one req_ready bit high per cycle, and only in state RUN.
REQ-007 Round-robin order: search starts at ptr+1 mod NUM_REQ; ptr updates to the granted index only on a transfer.
REQ-008 Operand of a transfer appears on eng_data_in with eng_valid_in=1 the next cycle; eng_valid_in=0 in every cycle with no prior-cycle transfer.
REQ-009 Tag shift register, depth ENG_LAT, entries {valid, id}, carries the requester index aligned with eng_valid_in.
REQ-010 When eng_valid_out=1 and the tag tail is valid, rsp_valid[tail id] and rsp_data=eng_data_out are registered out the next cycle.
REQ-011 Accept-to-rsp_valid latency is exactly ENG_LAT+2 cycles; results return in issue order.
REQ-012 Consumers cannot stall: rsp_valid is a one-cycle strobe with no ready.
REQ-013 err_spurious sets when eng_valid_out=1 with an invalid tag tail (no rsp generated), or when the tail is valid and eng_valid_out=0 (tag dropped, no rsp); it clears only on reset.
REQ-014 inflight increments on a transfer and decrements on any rsp_valid or dropped tag; a simultaneous increment and decrement leaves it unchanged.
REQ-015 FSM states RUN, DRAIN, HOLD: RUN->DRAIN when drain_req=1; DRAIN->HOLD when inflight=0; HOLD->RUN when drain_req=0.
REQ-016 Deasserting drain_req during DRAIN has no effect until HOLD is reached.
REQ-017 drain_done=1 exactly while in HOLD, registered.
REQ-018 When drain_req rises in the same cycle as a transfer, the transfer completes and DRAIN waits for it.

Reset
REQ-019 rst_n low asynchronously forces these values:
- state=RUN, ptr=NUM_REQ-1 (requester 0 wins first)
- tag pipe all invalid, inflight=0
- eng_valid_in=0, eng_data_in=0, rsp_valid=0, rsp_data=0
- drain_done=0, err_spurious=0
REQ-020 Reset mid-operation discards in-flight tags; engine results arriving after reset release set err_spurious.

Structure
REQ-021 Shared package tanh_sched_pkg holds the state enum (RUN, DRAIN, HOLD) and defaults for NUM_REQ, DATA_W and ENG_LAT.
REQ-022 Round-robin logic lives in sub-module rr_arbiter (inputs: req, ptr, enable; output: one-hot grant); all else is in tanh_scheduler.

Verification
REQ-023 The bench uses an engine model with ENG_LAT=4, output = input XOR 0xFFFF_FFFF.
REQ-024 Single request: requester 2 sends 0x3F80_0000 at cycle 10 -> eng_valid_in at 11; rsp_valid=4'b0100 and rsp_data=0xC07F_FFFF at 16.
REQ-025 All four requesters valid continuously -> grants 0,1,2,3,0 on consecutive cycles; inflight saturates at 6.
REQ-026 Drain: drain_req=1 with 3 in flight -> req_ready=0 from that cycle; drain_done=1 the cycle after inflight reaches 0; drain_req=0 -> grants resume the next cycle.
REQ-027 Spurious result: eng_valid_out pulsed with the pipe empty -> err_spurious=1 and held; no rsp_valid.
REQ-028 Reset pulse with 2 in flight -> all outputs return to their reset values immediately; the late engine results set err_spurious; a new request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/tanh_sched_pkg.sv
// Shared types and defaults for the Tanh engine scheduler.
// Holds the scheduler state enum and the default geometry of the block.
package tanh_sched_pkg;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefEngLat  = 4;
    localparam int unsigned InflightW  = 5;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHold
    } sched_state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        grant = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (enable && !found && req[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tanh_scheduler.sv
// Shares one fixed-latency Tanh engine among NUM_REQ requesters.
// A tag pipe tracks which requester owns each engine result; drain support empties the pipe.
module tanh_scheduler
    import tanh_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ENG_LAT = DefEngLat
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      eng_valid_in,
    output logic [DATA_W-1:0]         eng_data_in,
    input  logic                      eng_valid_out,
    input  logic [DATA_W-1:0]         eng_data_out,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic [InflightW-1:0]      inflight,
    output logic                      err_spurious
);

    localparam int unsigned IdW = idx_width(NUM_REQ);

    sched_state_e         state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant;
    logic                 arb_en;
    logic                 transfer;
    logic [IdW-1:0]       grant_id;
    logic [DATA_W-1:0]    grant_data;

    logic                 eng_valid_in_q;
    logic [DATA_W-1:0]    eng_data_in_q;
    logic [IdW-1:0]       issue_id_q;

    logic [ENG_LAT-1:0]   tag_vld_q;
    logic [IdW-1:0]       tag_id_q [ENG_LAT];
    logic                 tail_vld;
    logic [IdW-1:0]       tail_id;

    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q;
    logic                 rsp_fire;
    logic                 drop_d, drop_q;
    logic                 spur_d;
    logic                 err_q;
    logic [InflightW-1:0] inflight_q, inflight_d;
    logic                 drain_done_q;

    // ---------------------------------------------------------------- arbitration
    assign arb_en = (state_q == StRun);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IdW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id   = IdW'(i);
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_d = transfer ? grant_id : ptr_q;

    // ---------------------------------------------------------------- issue stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid_in_q <= 1'b0;
            eng_data_in_q  <= '0;
            issue_id_q     <= '0;
            ptr_q          <= IdW'(NUM_REQ - 1);
        end else begin
            eng_valid_in_q <= transfer;
            ptr_q          <= ptr_d;
            if (transfer) begin
                eng_data_in_q <= grant_data;
                issue_id_q    <= grant_id;
            end
        end
    end

    // Stage 0 of the tag pipe follows the engine input register, so the
    // tail lines up with eng_valid_out exactly ENG_LAT cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int i = 0; i < ENG_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= eng_valid_in_q;
            tag_id_q[0]  <= issue_id_q;
            for (int i = 1; i < ENG_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign tail_vld = tag_vld_q[ENG_LAT-1];
    assign tail_id  = tag_id_q[ENG_LAT-1];

    // ---------------------------------------------------------------- response
    always_comb begin
        rsp_fire    = eng_valid_out && tail_vld;
        drop_d      = tail_vld && !eng_valid_out;
        spur_d      = eng_valid_out && !tail_vld;
        rsp_valid_d = '0;
        if (rsp_fire) begin
            rsp_valid_d[tail_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            drop_q      <= drop_d;
            err_q       <= err_q | drop_d | spur_d;
            if (rsp_fire) begin
                rsp_data_q <= eng_data_out;
            end
        end
    end

    // ---------------------------------------------------------------- occupancy
    // Retirement is counted when the strobe (or the registered drop) is
    // visible, so a request stays counted through its response cycle.
    always_comb begin
        inflight_d = inflight_q;
        if (transfer && !((|rsp_valid_q) || drop_q)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!transfer && ((|rsp_valid_q) || drop_q)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // ---------------------------------------------------------------- drain FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain_req)         state_d = StDrain;
            StDrain: if (inflight_q == '0)  state_d = StHold;
            StHold:  if (!drain_req)        state_d = StRun;
            default:                        state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            inflight_q   <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            drain_done_q <= (state_d == StHold);
        end
    end

    assign eng_valid_in = eng_valid_in_q;
    assign eng_data_in  = eng_data_in_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign inflight     = inflight_q;
    assign drain_done   = drain_done_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_tanh_scheduler.sv
// Self-checking bench for tanh_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tanh_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             eng_valid_in;
    logic [DW-1:0]    eng_data_in;
    logic             eng_valid_out;
    logic [DW-1:0]    eng_data_out;
    logic             drain_req;
    logic             drain_done;
    logic [4:0]       inflight;
    logic             err_spurious;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tanh_scheduler #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .ENG_LAT (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .eng_valid_in  (eng_valid_in),
        .eng_data_in   (eng_data_in),
        .eng_valid_out (eng_valid_out),
        .eng_data_out  (eng_data_out),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .inflight      (inflight),
        .err_spurious  (err_spurious)
    );

    // Engine: fixed latency LAT, result = operand inverted. Not reset by rst_n.
    logic [LAT-1:0] ev_pipe = '0;
    logic [DW-1:0]  ed_pipe [LAT];
    logic           inj_v = 1'b0;
    logic [DW-1:0]  inj_d = '0;

    always @(posedge clk) begin
        ev_pipe    <= {ev_pipe[LAT-2:0], eng_valid_in};
        ed_pipe[0] <= eng_data_in ^ 32'hFFFF_FFFF;
        for (int k = 1; k < LAT; k++) ed_pipe[k] <= ed_pipe[k-1];
    end

    assign eng_valid_out = ev_pipe[LAT-1] | inj_v;
    assign eng_data_out  = inj_v ? inj_d : ed_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        bit          ret;
    } item_t;

    item_t       q[$];
    int          m_state;   // 0 run, 1 drain, 2 hold
    int          m_ptr;
    bit          m_err;
    bit          m_prev_xfer;
    logic [31:0] m_prev_data;
    int          max_inflight = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_state     = 0;
            m_ptr       = NR - 1;
            m_err       = 1'b0;
            m_prev_xfer = 1'b0;
            m_prev_data = '0;
        end else begin
            logic [NR-1:0] exp_ready;
            logic [NR-1:0] exp_rsp;
            logic [31:0]   exp_rdata;
            int            g;
            int            cnt;
            exp_ready = '0;
            exp_rsp   = '0;
            exp_rdata = '0;
            g         = -1;
            if (m_state == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            if (q.size() > 0 && q[0].due == cyc && q[0].ret) begin
                exp_rsp[q[0].id] = 1'b1;
                exp_rdata        = q[0].data;
            end
            cnt = q.size();
            if (cnt > max_inflight) max_inflight = cnt;

            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("eng_valid_in", 64'(eng_valid_in), 64'(m_prev_xfer));
            if (m_prev_xfer) check("eng_data_in", 64'(eng_data_in), 64'(m_prev_data));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
            if (exp_rsp != 0) check("rsp_data", 64'(rsp_data), 64'(exp_rdata));
            check("inflight", 64'(inflight), 64'(cnt));
            check("drain_done", 64'(drain_done), 64'(m_state == 2));
            check("err_spurious", 64'(err_spurious), 64'(m_err));

            if (m_state == 0 && drain_req)       m_state = 1;
            else if (m_state == 1 && cnt == 0)   m_state = 2;
            else if (m_state == 2 && !drain_req) m_state = 0;

            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            // A result is owed on the engine output the cycle before its strobe.
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                q[0].ret = eng_valid_out;
                if (!eng_valid_out) m_err = 1'b1;
            end else if (eng_valid_out) begin
                m_err = 1'b1;
            end

            m_prev_xfer = (g >= 0);
            if (g >= 0) begin
                m_prev_data = req_data[g*DW +: DW];
                q.push_back('{due: cyc + LAT + 2, id: g,
                              data: req_data[g*DW +: DW] ^ 32'hFFFF_FFFF, ret: 1'b0});
                m_ptr = g;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [NR-1:0] gexp [5];
    logic [NR-1:0] gseen [5];
    int c0, done_cyc, zero_cyc;

    initial begin
        req_valid = '0;
        req_data  = '0;
        drain_req = 1'b0;
        gexp      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        #2;
        check("reset eng_valid_in", 64'(eng_valid_in), 64'd0);
        check("reset eng_data_in", 64'(eng_data_in), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        check("reset inflight", 64'(inflight), 64'd0);
        check("reset drain_done", 64'(drain_done), 64'd0);
        check("reset err_spurious", 64'(err_spurious), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // All four requesters continuously valid.
        tick;
        req_valid = 4'b1111;
        req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            gseen[k] = req_ready;
            if (k < 4) tick;
        end
        for (int k = 0; k < 5; k++) check($sformatf("grant %0d", k), 64'(gseen[k]), 64'(gexp[k]));
        repeat (4) @(negedge clk);
        check("inflight saturated", 64'(inflight), 64'd6);
        tick;
        req_valid = '0;
        repeat (10) tick;
        check("model max inflight", 64'(max_inflight), 64'd6);

        // Single request from requester 2.
        tick;
        req_valid           = 4'b0100;
        req_data[2*DW +: DW] = 32'h3F80_0000;
        @(negedge clk);
        check("single ready", 64'(req_ready), 64'b0100);
        tick;
        req_valid = '0;
        @(negedge clk);
        check("single eng_valid_in", 64'(eng_valid_in), 64'd1);
        check("single eng_data_in", 64'(eng_data_in), 64'h3F80_0000);
        repeat (4) tick;
        @(negedge clk);
        check("single no early rsp", 64'(rsp_valid), 64'd0);
        tick;
        @(negedge clk);
        check("single rsp_valid", 64'(rsp_valid), 64'b0100);
        check("single rsp_data", 64'(rsp_data), 64'hC07F_FFFF);
        repeat (3) tick;

        // Drain with three in flight; a brief drain_req drop mid-drain is ignored.
        tick;
        c0        = cyc;
        req_valid = 4'b1111;
        tick;
        tick;
        tick;
        req_valid = '0;
        drain_req = 1'b1;
        @(negedge clk);
        check("drain inflight 3", 64'(inflight), 64'd3);
        check("drain ready off", 64'(req_ready), 64'd0);
        tick;
        req_valid = 4'b1111;
        @(negedge clk);
        check("drain blocks grants", 64'(req_ready), 64'd0);
        done_cyc = -1;
        zero_cyc = -1;
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            tick;
            if (k == 0) drain_req = 1'b0;
            if (k == 1) drain_req = 1'b1;
            @(negedge clk);
            if (inflight == 0 && zero_cyc < 0) zero_cyc = cyc;
            if (drain_done && done_cyc < 0) done_cyc = cyc;
        end
        check("drain_done latency", 64'(done_cyc - c0), 64'd10);
        check("drain_done after empty", 64'(done_cyc - zero_cyc), 64'd1);
        tick;
        req_valid = 4'b0010;
        @(negedge clk);
        check("hold no grant", 64'(req_ready), 64'd0);
        tick;
        drain_req = 1'b0;
        @(negedge clk);
        check("hold still done", 64'(drain_done), 64'd1);
        check("hold no grant on release", 64'(req_ready), 64'd0);
        tick;
        @(negedge clk);
        check("grant resumes", 64'(req_ready), 64'b0010);
        tick;
        req_valid = '0;
        repeat (10) tick;

        // drain_req rises together with a transfer; drain waits for it.
        tick;
        c0        = cyc;
        req_valid = 4'b0001;
        drain_req = 1'b1;
        @(negedge clk);
        check("drain+xfer ready", 64'(req_ready), 64'b0001);
        tick;
        req_valid = '0;
        done_cyc  = -1;
        for (int k = 0; k < 40 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (drain_done) done_cyc = cyc;
            else tick;
        end
        check("drain+xfer done latency", 64'(done_cyc - c0), 64'd8);
        tick;
        drain_req = 1'b0;
        repeat (3) tick;

        // Spurious engine result with an empty pipe.
        tick;
        inj_v = 1'b1;
        inj_d = 32'hDEAD_BEEF;
        @(negedge clk);
        check("spurious before", 64'(err_spurious), 64'd0);
        tick;
        inj_v = 1'b0;
        @(negedge clk);
        check("spurious set", 64'(err_spurious), 64'd1);
        check("spurious no rsp", 64'(rsp_valid), 64'd0);
        repeat (4) tick;
        @(negedge clk);
        check("spurious sticky", 64'(err_spurious), 64'd1);

        // Reset with two in flight.
        tick;
        req_valid = 4'b0011;
        tick;
        tick;
        req_valid = '0;
        #1;
        check("pre-reset inflight", 64'(inflight), 64'd2);
        rst_n = 1'b0;
        #1;
        check("async eng_valid_in", 64'(eng_valid_in), 64'd0);
        check("async eng_data_in", 64'(eng_data_in), 64'd0);
        check("async rsp_data", 64'(rsp_data), 64'd0);
        check("async inflight", 64'(inflight), 64'd0);
        check("async drain_done", 64'(drain_done), 64'd0);
        check("async err", 64'(err_spurious), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset err clear", 64'(err_spurious), 64'd0);
        repeat (4) tick;
        @(negedge clk);
        check("late result err", 64'(err_spurious), 64'd1);
        tick;
        req_valid = 4'b1111;
        @(negedge clk);
        check("post-reset first grant", 64'(req_ready), 64'b0001);
        tick;
        req_valid = '0;
        repeat (10) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
